// File: rtl/ibex_pkg.sv
// Shared types for the ibex retirement tracer: the compact trace record and
// helpers used to format it from the RVFI port.
package ibex_pkg;

  typedef struct packed {
    logic [63:0] cycle;
    logic [31:0] hart;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] insn;
    logic [1:0]  mode;
    logic        trap;
    logic        halt;
    logic        intr;
    logic        compressed;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_data;
  } trace_rec_t;

  localparam int unsigned TraceRecW = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_kind_e;

  // A write mask takes priority: stores report write data even if rmask is set.
  function automatic mem_kind_e mem_kind_of(input logic [3:0] rmask,
                                            input logic [3:0] wmask);
    if (wmask != 4'b0000) begin
      return MEM_WRITE;
    end else if (rmask != 4'b0000) begin
      return MEM_READ;
    end
    return MEM_NONE;
  endfunction

  function automatic logic is_compressed(input logic [31:0] insn);
    return insn[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// Generic registered FIFO without fall-through. Pointers carry an extra wrap
// bit so full and empty are distinguishable. Depth must be a power of two >= 2.
module ibex_trace_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0] wr_idx, rd_idx;
  logic             push_acc, pop_acc;
  logic [Width-1:0] mem_q [Depth];

  assign wr_idx  = wr_ptr_q[AddrW-1:0];
  assign rd_idx  = rd_ptr_q[AddrW-1:0];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) && (wr_idx == rd_idx);

  // When full, a same-cycle pop frees the head slot, which the push then reuses.
  assign pop_acc  = pop_i & ~empty_o;
  assign push_acc = push_i & (~full_o | pop_acc);

  assign wr_ptr_d = wr_ptr_q + PtrW'(push_acc);
  assign rd_ptr_d = rd_ptr_q + PtrW'(pop_acc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_idx];

endmodule

// File: rtl/ibex_rvfi_tracer.sv
// Synthesizable retirement tracer: formats one record per RVFI retirement,
// buffers it, checks retirement order and counts retired/dropped records.
module ibex_rvfi_tracer
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned DropCntW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         hart_id_i,

  input  logic                rvfi_valid,
  input  logic [63:0]         rvfi_order,
  input  logic [31:0]         rvfi_insn,
  input  logic                rvfi_trap,
  input  logic                rvfi_halt,
  input  logic                rvfi_intr,
  input  logic [1:0]          rvfi_mode,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [31:0]         rvfi_pc_wdata,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic [31:0]         rvfi_mem_addr,
  input  logic [3:0]          rvfi_mem_rmask,
  input  logic [3:0]          rvfi_mem_wmask,
  input  logic [31:0]         rvfi_mem_rdata,
  input  logic [31:0]         rvfi_mem_wdata,

  output logic                trace_valid_o,
  input  logic                trace_ready_i,
  output trace_rec_t          trace_rec_o,
  output logic                order_err_o,
  output logic                overflow_o,
  output logic [DropCntW-1:0] drop_cnt_o,
  output logic [63:0]         retired_cnt_o
);

  logic [31:0] wmask_bits, rmask_bits;
  mem_kind_e   mem_kind;
  trace_rec_t  rec_d;
  trace_rec_t  fifo_head;
  logic        fifo_full, fifo_empty;
  logic        pop, drop;

  logic [63:0]         cycle_q;
  logic [63:0]         retired_q;
  logic [DropCntW-1:0] drop_cnt_q;
  logic                overflow_q;
  logic                order_first_q;
  logic [63:0]         order_exp_q;
  logic                order_err_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
    assign wmask_bits[gi*8 +: 8] = {8{rvfi_mem_wmask[gi]}};
    assign rmask_bits[gi*8 +: 8] = {8{rvfi_mem_rmask[gi]}};
  end

  assign mem_kind = mem_kind_of(rvfi_mem_rmask, rvfi_mem_wmask);

  always_comb begin
    rec_d            = '0;
    rec_d.cycle      = cycle_q;
    rec_d.hart       = hart_id_i;
    rec_d.order      = rvfi_order;
    rec_d.pc         = rvfi_pc_rdata;
    rec_d.next_pc    = rvfi_pc_wdata;
    rec_d.insn       = rvfi_insn;
    rec_d.mode       = rvfi_mode;
    rec_d.trap       = rvfi_trap;
    rec_d.halt       = rvfi_halt;
    rec_d.intr       = rvfi_intr;
    rec_d.compressed = is_compressed(rvfi_insn);
    rec_d.mem_rmask  = rvfi_mem_rmask;
    rec_d.mem_wmask  = rvfi_mem_wmask;
    // x0 writes are architecturally invisible, so they are reported as none.
    if (rvfi_rd_addr != 5'd0) begin
      rec_d.rd_addr  = rvfi_rd_addr;
      rec_d.rd_wdata = rvfi_rd_wdata;
    end
    unique case (mem_kind)
      MEM_WRITE: begin
        rec_d.mem_addr = rvfi_mem_addr;
        rec_d.mem_data = rvfi_mem_wdata & wmask_bits;
      end
      MEM_READ: begin
        rec_d.mem_addr = rvfi_mem_addr;
        rec_d.mem_data = rvfi_mem_rdata & rmask_bits;
      end
      default: ;
    endcase
  end

  assign trace_valid_o = ~fifo_empty;
  assign pop           = trace_valid_o & trace_ready_i;
  assign drop          = rvfi_valid & fifo_full & ~pop;

  ibex_trace_fifo #(
    .Width (TraceRecW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rvfi_valid),
    .wdata_i (rec_d),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .rdata_o (fifo_head)
  );

  // Storage is not reset, so the head is masked to zero whenever nothing is valid.
  assign trace_rec_o = trace_valid_o ? fifo_head : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q    <= '0;
      retired_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (rvfi_valid) begin
        retired_q <= retired_q + 64'd1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != {DropCntW{1'b1}}) begin
          drop_cnt_q <= drop_cnt_q + DropCntW'(1);
        end
      end
    end
  end

  // Expected order always follows the last retirement, so one gap flags once
  // and checking resynchronises on the next instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_first_q <= 1'b1;
      order_exp_q   <= '0;
      order_err_q   <= 1'b0;
    end else if (rvfi_valid) begin
      order_first_q <= 1'b0;
      order_exp_q   <= rvfi_order + 64'd1;
      if (!order_first_q && (rvfi_order != order_exp_q)) begin
        order_err_q <= 1'b1;
      end
    end
  end

  assign retired_cnt_o = retired_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;
  assign order_err_o   = order_err_q;

endmodule

// File: tb/tb_ibex_rvfi_tracer.sv
// Self-checking bench for ibex_rvfi_tracer: directed scenarios plus random
// traffic compared against a queue-based model of the tracer's behaviour.
module tb_ibex_rvfi_tracer;
  import ibex_pkg::*;

  localparam int DEPTH    = 4;
  localparam int DROPW    = 3;
  localparam int DROP_MAX = (1 << DROPW) - 1;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic        trap;
    logic        halt;
    logic        intr;
  } ret_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [31:0]      hart_id_i;
  logic             rvfi_valid;
  logic [63:0]      rvfi_order;
  logic [31:0]      rvfi_insn;
  logic             rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]       rvfi_mode;
  logic [31:0]      rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0]       rvfi_rd_addr;
  logic [31:0]      rvfi_rd_wdata, rvfi_mem_addr;
  logic [3:0]       rvfi_mem_rmask, rvfi_mem_wmask;
  logic [31:0]      rvfi_mem_rdata, rvfi_mem_wdata;
  logic             trace_valid_o;
  logic             trace_ready_i;
  trace_rec_t       trace_rec_o;
  logic             order_err_o, overflow_o;
  logic [DROPW-1:0] drop_cnt_o;
  logic [63:0]      retired_cnt_o;

  ibex_rvfi_tracer #(
    .Depth    (DEPTH),
    .DropCntW (DROPW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .hart_id_i      (hart_id_i),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_insn      (rvfi_insn),
    .rvfi_trap      (rvfi_trap),
    .rvfi_halt      (rvfi_halt),
    .rvfi_intr      (rvfi_intr),
    .rvfi_mode      (rvfi_mode),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_pc_wdata  (rvfi_pc_wdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .rvfi_mem_rdata (rvfi_mem_rdata),
    .rvfi_mem_wdata (rvfi_mem_wdata),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_rec_o    (trace_rec_o),
    .order_err_o    (order_err_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o),
    .retired_cnt_o  (retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  trace_rec_t  mq[$];
  logic [63:0] m_cycle;
  logic [63:0] m_retired;
  int          m_drops;
  logic        m_ovf, m_oerr, m_first;
  logic [63:0] m_exp;
  logic [31:0] hart_val;

  ret_t cur_r;
  logic cur_v, cur_rdy;

  int errors = 0;
  int checks = 0;

  function automatic ret_t zero_ret();
    ret_t r;
    r = '0;
    return r;
  endfunction

  function automatic ret_t rand_ret(input logic [63:0] order);
    ret_t r;
    r.order    = order;
    r.insn     = $urandom;
    r.pc       = $urandom & 32'hFFFF_FFFE;
    r.npc      = $urandom & 32'hFFFF_FFFE;
    r.rd       = 5'($urandom_range(0, 31));
    r.rd_wdata = $urandom;
    r.mem_addr = $urandom;
    r.rmask    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    r.wmask    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    r.rdata    = $urandom;
    r.wdata    = $urandom;
    r.mode     = 2'($urandom_range(0, 3));
    r.trap     = 1'($urandom_range(0, 1));
    r.halt     = 1'($urandom_range(0, 1));
    r.intr     = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] keep;
    keep = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) keep = keep | (32'hFF << (8 * b));
    end
    return d & keep;
  endfunction

  function automatic trace_rec_t model_rec(input ret_t r, input logic [63:0] cyc);
    trace_rec_t e;
    e            = '0;
    e.cycle      = cyc;
    e.hart       = hart_val;
    e.order      = r.order;
    e.pc         = r.pc;
    e.next_pc    = r.npc;
    e.insn       = r.insn;
    e.mode       = r.mode;
    e.trap       = r.trap;
    e.halt       = r.halt;
    e.intr       = r.intr;
    e.compressed = ((r.insn % 4) != 3);
    if (r.rd != 0) begin
      e.rd_addr  = r.rd;
      e.rd_wdata = r.rd_wdata;
    end
    e.mem_rmask = r.rmask;
    e.mem_wmask = r.wmask;
    if (r.rmask != 0 || r.wmask != 0) e.mem_addr = r.mem_addr;
    if (r.wmask != 0)      e.mem_data = keep_bytes(r.wdata, r.wmask);
    else if (r.rmask != 0) e.mem_data = keep_bytes(r.rdata, r.rmask);
    return e;
  endfunction

  function automatic trace_rec_t model_head();
    trace_rec_t e;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    return e;
  endfunction

  function automatic int model_drop();
    return (m_drops > DROP_MAX) ? DROP_MAX : m_drops;
  endfunction

  task automatic drive(input logic v, input ret_t r, input logic rdy);
    cur_v = v; cur_r = r; cur_rdy = rdy;
    rvfi_valid     = v;
    rvfi_order     = r.order;
    rvfi_insn      = r.insn;
    rvfi_pc_rdata  = r.pc;
    rvfi_pc_wdata  = r.npc;
    rvfi_rd_addr   = r.rd;
    rvfi_rd_wdata  = r.rd_wdata;
    rvfi_mem_addr  = r.mem_addr;
    rvfi_mem_rmask = r.rmask;
    rvfi_mem_wmask = r.wmask;
    rvfi_mem_rdata = r.rdata;
    rvfi_mem_wdata = r.wdata;
    rvfi_mode      = r.mode;
    rvfi_trap      = r.trap;
    rvfi_halt      = r.halt;
    rvfi_intr      = r.intr;
    trace_ready_i  = rdy;
  endtask

  // Advance one clock, updating the model with whatever is currently driven.
  task automatic tick();
    trace_rec_t rec;
    bit pop, push;
    rec  = '0;
    pop  = (mq.size() != 0) && cur_rdy;
    push = 0;
    if (cur_v) begin
      rec = model_rec(cur_r, m_cycle);
      m_retired = m_retired + 1;
      if (!m_first && cur_r.order != m_exp) m_oerr = 1'b1;
      m_first = 1'b0;
      m_exp   = cur_r.order + 1;
      if (mq.size() < DEPTH || pop) push = 1;
      else begin
        m_drops = m_drops + 1;
        m_ovf   = 1'b1;
      end
    end
    @(posedge clk_i);
    if (pop) begin
      $display("pop  order=%0d cycle=%0d pc=%h insn=%h", mq[0].order, mq[0].cycle, mq[0].pc, mq[0].insn);
      void'(mq.pop_front());
    end
    if (push) mq.push_back(rec);
    else if (cur_v) $display("drop order=%0d", cur_r.order);
    m_cycle = m_cycle + 1;
    @(negedge clk_i);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cycle = 0; m_retired = 0; m_drops = 0;
    m_ovf = 0; m_oerr = 0; m_first = 1; m_exp = 0;
  endtask

  task automatic apply_reset();
    drive(1'b0, zero_ret(), 1'b0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && mq.size() != 0; i++) begin
      drive(1'b0, zero_ret(), 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", trace_valid_o); end
    checks++; if (trace_rec_o !== '0) begin errors++; $display("FAIL reset_rec got=%h exp=0", trace_rec_o); end
    checks++; if (order_err_o !== 1'b0) begin errors++; $display("FAIL reset_order_err got=%b exp=0", order_err_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    checks++; if (drop_cnt_o !== '0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt_o); end
    checks++; if (retired_cnt_o !== 64'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired_cnt_o); end
  endtask

  task automatic test_first_retire();
    ret_t r;
    trace_rec_t e;
    r = zero_ret();
    r.pc = 32'h80; r.npc = 32'h84; r.insn = 32'h0050_0093;
    r.rd = 5'd1; r.rd_wdata = 32'd5; r.order = 64'd1; r.mode = 2'b11;
    drive(1'b1, r, 1'b0);
    #1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL first_no_fallthrough got=%b exp=0", trace_valid_o); end
    tick();
    drive(1'b0, zero_ret(), 1'b0);
    e = model_head();
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", trace_valid_o); end
    checks++; if (trace_rec_o.rd_wdata !== 32'd5) begin errors++; $display("FAIL first_rd_wdata got=%h exp=5", trace_rec_o.rd_wdata); end
    checks++; if (trace_rec_o.compressed !== 1'b0) begin errors++; $display("FAIL first_compressed got=%b exp=0", trace_rec_o.compressed); end
    checks++; if (trace_rec_o.order !== 64'd1) begin errors++; $display("FAIL first_order got=%0d exp=1", trace_rec_o.order); end
    checks++; if (trace_rec_o !== e) begin errors++; $display("FAIL first_rec got=%h exp=%h", trace_rec_o, e); end
    checks++; if (retired_cnt_o !== 64'd1) begin errors++; $display("FAIL first_retired got=%0d exp=1", retired_cnt_o); end
  endtask

  task automatic test_compressed_store();
    ret_t r;
    trace_rec_t e;
    r = zero_ret();
    r.insn = 32'h0000_C10C; r.wmask = 4'b0011; r.wdata = 32'hDEAD_BEEF;
    r.mem_addr = 32'h0000_1000; r.order = 64'd2; r.pc = 32'h84; r.npc = 32'h86;
    drive(1'b1, r, 1'b1);
    tick();
    drive(1'b0, zero_ret(), 1'b0);
    e = model_head();
    checks++; if (trace_rec_o.compressed !== 1'b1) begin errors++; $display("FAIL cstore_compressed got=%b exp=1", trace_rec_o.compressed); end
    checks++; if (trace_rec_o.mem_data !== 32'h0000_BEEF) begin errors++; $display("FAIL cstore_mem_data got=%h exp=0000beef", trace_rec_o.mem_data); end
    checks++; if (trace_rec_o !== e) begin errors++; $display("FAIL cstore_rec got=%h exp=%h", trace_rec_o, e); end
    drain();
  endtask

  task automatic test_x0();
    ret_t r;
    trace_rec_t e;
    r = rand_ret(64'd3);
    r.rd = 5'd0; r.rd_wdata = 32'h1234;
    drive(1'b1, r, 1'b0);
    tick();
    drive(1'b0, zero_ret(), 1'b0);
    e = model_head();
    checks++; if (trace_rec_o.rd_addr !== 5'd0) begin errors++; $display("FAIL x0_rd_addr got=%0d exp=0", trace_rec_o.rd_addr); end
    checks++; if (trace_rec_o.rd_wdata !== 32'd0) begin errors++; $display("FAIL x0_rd_wdata got=%h exp=0", trace_rec_o.rd_wdata); end
    checks++; if (trace_rec_o !== e) begin errors++; $display("FAIL x0_rec got=%h exp=%h", trace_rec_o, e); end
    drain();
  endtask

  task automatic test_order_gap();
    logic [63:0] ords [4];
    logic        want [4];
    ords[0] = 1; ords[1] = 2; ords[2] = 4; ords[3] = 5;
    want[0] = 0; want[1] = 0; want[2] = 1; want[3] = 1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rand_ret(ords[i]), 1'b1);
      tick();
      checks++; if (order_err_o !== want[i]) begin errors++; $display("FAIL order_gap_%0d got=%b exp=%b", ords[i], order_err_o, want[i]); end
      checks++; if (trace_rec_o !== model_head()) begin errors++; $display("FAIL order_gap_rec_%0d got=%h exp=%h", ords[i], trace_rec_o, model_head()); end
    end
    drain();
    checks++; if (order_err_o !== 1'b1) begin errors++; $display("FAIL order_gap_sticky got=%b exp=1", order_err_o); end
  endtask

  task automatic test_overflow();
    trace_rec_t held;
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, rand_ret(64'(i)), 1'b0);
      tick();
      if (i == 1) held = model_head();
      checks++; if (trace_rec_o !== held) begin errors++; $display("FAIL ovf_head_stable_%0d got=%h exp=%h", i, trace_rec_o, held); end
    end
    drive(1'b0, zero_ret(), 1'b0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    checks++; if (int'(drop_cnt_o) !== 2) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt_o); end
    checks++; if (retired_cnt_o !== 64'd6) begin errors++; $display("FAIL ovf_retired got=%0d exp=6", retired_cnt_o); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (trace_valid_o !== 1'b1 || trace_rec_o.order !== 64'(i)) begin
        errors++; $display("FAIL ovf_drain_%0d got valid=%b order=%0d exp valid=1 order=%0d", i, trace_valid_o, trace_rec_o.order, i);
      end
      checks++; if (trace_rec_o !== model_head()) begin errors++; $display("FAIL ovf_drain_rec_%0d got=%h exp=%h", i, trace_rec_o, model_head()); end
      drive(1'b0, zero_ret(), 1'b1);
      tick();
    end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", trace_valid_o); end
  endtask

  task automatic test_full_pop();
    int n;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, rand_ret(64'(i)), 1'b0);
      tick();
    end
    drive(1'b1, rand_ret(64'd5), 1'b1);
    tick();
    drive(1'b0, zero_ret(), 1'b0);
    checks++; if (int'(drop_cnt_o) !== model_drop() || drop_cnt_o !== '0) begin errors++; $display("FAIL fullpop_drop got=%0d exp=0", drop_cnt_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got=%b exp=0", overflow_o); end
    checks++; if (retired_cnt_o !== 64'd5) begin errors++; $display("FAIL fullpop_retired got=%0d exp=5", retired_cnt_o); end
    n = 0;
    while (trace_valid_o === 1'b1 && n < 10) begin
      checks++; if (trace_rec_o !== model_head()) begin errors++; $display("FAIL fullpop_rec_%0d got=%h exp=%h", n, trace_rec_o, model_head()); end
      drive(1'b0, zero_ret(), 1'b1);
      tick();
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL fullpop_occupancy got=%0d exp=4", n); end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    for (int i = 1; i <= DEPTH + 10; i++) begin
      drive(1'b1, rand_ret(64'(i)), 1'b0);
      tick();
    end
    drive(1'b0, zero_ret(), 1'b0);
    checks++; if (int'(drop_cnt_o) !== DROP_MAX) begin errors++; $display("FAIL sat_drop_cnt got=%0d exp=%0d", drop_cnt_o, DROP_MAX); end
    checks++; if (retired_cnt_o !== 64'(DEPTH + 10)) begin errors++; $display("FAIL sat_retired got=%0d exp=%0d", retired_cnt_o, DEPTH + 10); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, rand_ret(64'(i)), 1'b0);
      tick();
    end
    drive(1'b0, zero_ret(), 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", trace_valid_o); end
    checks++; if (trace_rec_o !== '0) begin errors++; $display("FAIL midrst_rec got=%h exp=0", trace_rec_o); end
    checks++; if (retired_cnt_o !== 64'd0) begin errors++; $display("FAIL midrst_retired got=%0d exp=0", retired_cnt_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back_random();
    logic [63:0] ord;
    int exp_drop;
    apply_reset();
    ord = 64'd100;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        ord = ord + (($urandom_range(0, 24) == 0) ? 64'd2 : 64'd1);
        drive(1'b1, rand_ret(ord), 1'($urandom_range(0, 3) != 0));
      end else begin
        drive(1'b0, zero_ret(), 1'($urandom_range(0, 3) != 0));
      end
      tick();
      exp_drop = model_drop();
      checks++; if (trace_valid_o !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, trace_valid_o, mq.size() != 0); end
      checks++; if (trace_rec_o !== model_head()) begin errors++; $display("FAIL rand_rec c=%0d got=%h exp=%h", c, trace_rec_o, model_head()); end
      checks++; if (retired_cnt_o !== m_retired) begin errors++; $display("FAIL rand_retired c=%0d got=%0d exp=%0d", c, retired_cnt_o, m_retired); end
      checks++; if (order_err_o !== m_oerr) begin errors++; $display("FAIL rand_order_err c=%0d got=%b exp=%b", c, order_err_o, m_oerr); end
      checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rand_overflow c=%0d got=%b exp=%b", c, overflow_o, m_ovf); end
      checks++; if (int'(drop_cnt_o) !== exp_drop) begin errors++; $display("FAIL rand_drop c=%0d got=%0d exp=%0d", c, drop_cnt_o, exp_drop); end
    end
  endtask

  initial begin
    hart_val  = $urandom;
    hart_id_i = hart_val;
    model_reset();
    test_reset();
    test_first_retire();
    test_compressed_store();
    test_x0();
    test_order_gap();
    test_overflow();
    test_full_pop();
    test_drop_saturate();
    test_reset_midstream();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
